// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   - request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
//   - FSM state enum mau_state_t
//   - MAU_DEPTH: default number of 32-bit words in the data memory
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int MAU_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_t;

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: purely combinational lane logic for the memory access unit.
//   Load path : picks the byte/halfword lane selected by addr_lo out of the
//               memory word, moves it to bit 0 and zero- or sign-extends it.
//               Word loads pass through unchanged.
//   Store path: replaces the selected lane of the old memory word with the
//               right-justified store data. Word stores return wdata.
// Ports:
//   size      in  2   request size (mau_pkg SZ_* encodings)
//   addr_lo   in  2   byte address bits [1:0] (little-endian lane select)
//   sign_ext  in  1   1 = sign-extend sub-word loads from the lane MSB
//   word      in  32  word read from memory
//   wdata     in  32  store data, right-justified
//   load_data out 32  extracted/extended load result
//   store_word out 32 merged word to write back
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the CPU datapath and a
// word-indexed data memory. Byte/halfword/word requests are converted to
// full-word memory accesses; sub-word stores are done by read-modify-write.
//
// Optional feature macro: MAU_SIGNED_LOAD_EN
//   defined   -> req_signed=1 sign-extends byte/halfword loads
//   undefined -> req_signed ignored, sub-word loads are zero-extended
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Once raised, resp_valid and the
// response data stay stable until that transfer.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend sub-word load (macro dependent)
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  load result (0 for stores/errors), error flag
//   address               word index to memory (req_addr[31:2])
//   write_data            full word to memory
//   memRead, memWrite     one-cycle registered memory strobes
//   bytSig, halfword      tied 0 (unit merges lanes itself)
//   mem_rdata             word returned by memory
//   state_dbg             current FSM state (mau_state_t encoding)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DEPTH = MAU_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        memRead,
  output logic        memWrite,
  output logic        bytSig,
  output logic        halfword,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

`ifdef MAU_SIGNED_LOAD_EN
  localparam logic SIGNED_LOAD_EN = 1'b1;
`else
  localparam logic SIGNED_LOAD_EN = 1'b0;
`endif

  mau_state_t  state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic        take_req;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign bytSig    = 1'b0;
  assign halfword  = 1'b0;
  assign state_dbg = state;

  assign take_req = (state == ST_IDLE) && req_ready && req_valid;

  // Evaluated on the live request so an error goes straight to RESP.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL)                              req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])            req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))           req_err = 1'b1;
  end

  // Lane logic works on the latched request and the live memory word, so
  // both the load result and the merged store word are ready at the end of RD.
  mau_lane_align u_lane_align (
    .size       (size_q),
    .addr_lo    (addr_lo_q),
    .sign_ext   (signed_q & SIGNED_LOAD_EN),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'h0;
      address    <= 32'h0;
      write_data <= 32'h0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_req) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            address   <= {2'b00, req_addr[31:2]};
            if (req_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              // Full-word store needs no read of the old word.
              state      <= ST_WR;
              memWrite   <= 1'b1;
              write_data <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state   <= ST_RD;
              memRead <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_RD: begin
          memRead <= 1'b0;
          if (write_q) begin
            state      <= ST_WR;
            memWrite   <= 1'b1;
            write_data <= store_word;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        ST_WR: begin
          memWrite   <= 1'b0;
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the word-indexed data memory. Accepts byte, halfword and word requests on a valid/ready handshake and converts byte addresses to word indices. Extracts and extends sub-word load data. Stores sub-words by read-modify-write, so the memory is always accessed in full-word mode and any byte lane is reachable.

## Interface
- `DEPTH`, 32: number of 32-bit words in the data memory; word indices at or above `DEPTH` are errors.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend a sub-word load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word stores.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned, out-of-range or illegal-size request.
- `address` out 32: word index, `req_addr[31:2]` zero-extended.
- `write_data` out 32: full word driven to memory.
- `memRead` out 1: memory read strobe.
- `memWrite` out 1: memory write strobe.
- `bytSig` out 1: tied 0; the unit does its own lane merging.
- `halfword` out 1: tied 0.
- `mem_rdata` in 32: word returned by memory.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request fields.
- Error check at acceptance:
  - Halfword with `addr[0]`=1 is an error.
  - Word with `addr[1:0]`≠0 is an error.
  - `req_size`=11 is an error.
  - Word index ≥ `DEPTH` is an error.
  - On error, go to RESP with `resp_err`=1 and make no memory access.
- Load: IDLE→RD→RESP.
  - In RD, `memRead`=1.
  - `mem_rdata` is captured at the end of RD.
- Word store: IDLE→WR→RESP.
  - In WR, `memWrite`=1 and `write_data`=`req_wdata`.
- Sub-word store: IDLE→RD→WR→RESP.
  - In RD, read the old word.
  - In WR, write the old word with the target lane replaced.
- Lanes are little-endian:
  - Byte lane k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half lane h = `addr[1]` occupies bits [16h+15:16h].
- Load extraction: the lane is shifted to bit 0, then zero- or sign-extended to 32 bits. Word loads pass through unchanged.
- RESP:
  - `resp_valid` is held, with stable data, until `resp_ready`, then the unit returns to IDLE.
  - `req_ready`=0 in RD, WR and RESP; requests are not accepted while a response is pending.
- `memRead` and `memWrite` are registered, never both 1, and each is high for exactly one cycle per access.
- `address` and `write_data` are stable whenever either strobe is high.

## Timing
- Request accepted at edge T.
- Load: `memRead` high in T..T+1; `resp_valid` from T+2.
- Word store: `memWrite` high in T..T+1; `resp_valid` from T+2.
- Sub-word store: RD in cycle T+1, WR in T+2, `resp_valid` from T+3.
- Error: `resp_valid`/`resp_err` from T+1, with no strobes.
- Reset values: all outputs 0, state IDLE, latched request cleared. `req_ready` goes to 1 on the first cycle after `reset` deasserts.
- Reset mid-operation:
  - Strobes drop immediately and no response is issued.
  - A sub-word store aborted in RD leaves memory unchanged.
  - A store aborted in WR leaves the target word undefined.
- `resp_ready` high with `resp_valid` low has no effect.
- `req_valid` outside IDLE is ignored, and the requester must hold it.

## Configuration
- `MAU_SIGNED_LOAD_EN` defined: `req_signed`=1 sign-extends byte and halfword loads from the lane MSB.
- `MAU_SIGNED_LOAD_EN` undefined: `req_signed` is ignored and all sub-word loads are zero-extended. All other behaviour is identical.

## Structure
- Package `mau_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum `mau_state_t`;
  - default `DEPTH` constant.
- Sub-module `mau_lane_align` is purely combinational and holds lane extraction and extension for loads, plus lane merge for stores. The top level holds the FSM, request/response registers and error check.

## Test plan
- Word store of 0xDEADBEEF to 0x10, then word load of 0x10 → `memWrite` at word 4, then `resp_rdata`=0xDEADBEEF at T+2.
- Byte store of 0xAA to 0x11 over word 0x11223344 → RD then WR with `write_data`=0x1122AA44; response at T+3.
- With memory word 0x80F0 at byte address 0x00:
  - signed byte load at 0x01 → 0xFFFFFF80 with the macro, 0x00000080 without.
  - signed halfword load at 0x00 → 0xFFFF80F0 with the macro.
- Halfword load at 0x03, word store at 0x06, and size 11 → `resp_err`=1 at T+1, no strobes, memory unchanged.
- Word address 0x80 with DEPTH=32 → `resp_err`=1.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid` and data stable, `req_ready`=0. Assert `reset` during WR of a store → outputs 0 at once, no response, `req_ready`=1 after release.
